// File: rtl/rv32_pipe_pkg.sv
// rtl/rv32_pipe_pkg.sv - shared RV32I pipeline types and constants
package rv32_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // x0 never carries a real dependency, so a load targeting it cannot stall ID.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer with memory watchdog and stall counter
module pipeline_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  input  logic        mem_val,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  pipe_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic             mem_timeout_q, mem_timeout_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic             load_use, dmem_stall, fetch_stall, timeout_hit;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign dmem_stall  = mem_val && !mem_ready;
  assign fetch_stall = !imem_ready;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (rst || state_q == HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dmem_stall) begin
      // Freeze everything upstream of MEM; the WB bubble stops a double write-back.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (fetch_stall) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // The first stall cycle is spent in RUN, so the count is compared after the increment.
  assign wait_cnt_inc = (state_q == RUN) ? CNT_W'(1) : wait_cnt_q + CNT_W'(1);
  assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      RUN: begin
        if (dmem_stall) begin
          wait_cnt_d = wait_cnt_inc;
          state_d    = MEM_WAIT;
          if (timeout_hit) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (!dmem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (timeout_hit) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (!pc_en && stall_cycles_q != 32'hFFFF_FFFF) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
